// File: rtl/tcdm_master_arb.sv
// tcdm_master_arb: round-robin N-to-1 arbiter sharing one TCDM network master port
module tcdm_master_arb #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddWidth      = 10,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter bit          WriteRespOn   = 1'b1,
  parameter int unsigned StallWidth    = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  output logic [NumReq-1:0]                     gnt_o,
  input  logic [NumReq-1:0][AddWidth-1:0]       add_i,
  input  logic [NumReq-1:0]                     wen_i,
  input  logic [NumReq-1:0][ReqDataWidth-1:0]   data_i,
  output logic [RespDataWidth-1:0]              rdata_o,
  output logic [NumReq-1:0]                     vld_o,
  output logic                                  req_o,
  input  logic                                  gnt_i,
  output logic [AddWidth-1:0]                   add_o,
  output logic                                  wen_o,
  output logic [ReqDataWidth-1:0]               data_o,
  input  logic [RespDataWidth-1:0]              rdata_i,
  input  logic                                  vld_i,
  output logic                                  stall_o,
  output logic                                  err_o
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam logic [IdxW:0] NumW = (IdxW+1)'(NumReq);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
  localparam logic [StallWidth-1:0] Thr = '1;
  logic [IdxW-1:0] ptr_q, ptr_d, lid_q, lid_d, pid_q, pid_d, win, idx;
  logic [IdxW:0] sum;
  logic lock_q, lock_d, pend_q, pend_d, err_q, err_d, found, hs, stalled;
  logic [StallWidth-1:0] stall_cnt_q, stall_cnt_d;
  // winner: held lock if its requester is still asking, else first request at or after ptr_q
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (IdxW+1)'(i);
      idx = IdxW'(sum >= NumW ? sum - NumW : sum);
      if (req_i[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    if (lock_q && req_i[lid_q]) begin
      found = 1'b1;
      win = lid_q;
    end
  end
  assign req_o   = found & ~rst_i;
  assign add_o   = req_o ? add_i[win] : '0;
  assign wen_o   = req_o ? wen_i[win] : 1'b0;
  assign data_o  = req_o ? data_i[win] : '0;
  assign gnt_o   = (req_o & gnt_i) ? (NumReq'(1) << win) : '0;
  assign vld_o   = (vld_i & pend_q) ? (NumReq'(1) << pid_q) : '0;
  assign rdata_o = rdata_i;
  assign stall_o = stall_cnt_q == Thr;
  assign err_o   = err_q;
  assign hs      = req_o & gnt_i;
  assign stalled = req_o & ~gnt_i;
  // next state: pointer advance, lock on stall, response tracking, stall count, sticky error
  always_comb begin
    ptr_d       = hs ? (win == LastIdx ? '0 : win + 1'b1) : ptr_q;
    lock_d      = stalled;
    lid_d       = stalled ? win : lid_q;
    pend_d      = hs & (~wen_o | WriteRespOn);
    pid_d       = hs ? win : pid_q;
    stall_cnt_d = stalled ? (stall_cnt_q == Thr ? Thr : stall_cnt_q + 1'b1) : '0;
    err_d       = err_q | (vld_i ^ pend_q);
  end
  // state registers, all cleared immediately by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lid_q       <= '0;
      pend_q      <= 1'b0;
      pid_q       <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lid_q       <= lid_d;
      pend_q      <= pend_d;
      pid_q       <= pid_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_tcdm_master_arb.sv
// tb_tcdm_master_arb: scoreboard bench for a 4-port (write responses) and a 3-port (no write responses) arbiter
module tb_tcdm_master_arb;
  localparam int AW = 10, DW = 32, THR = 15;
  typedef struct { int ptr; bit lock; int lid; bit pend; int pid; int cnt; bit err; } st_t;
  typedef struct { bit req; logic [3:0] gnt; logic [AW-1:0] add; bit wen; logic [DW-1:0] data; logic [3:0] vld; bit stall; bit err; } exp_t;
  typedef struct { exp_t e0; exp_t e1; logic [DW-1:0] rd; } ent_t;
  logic clk = 1'b0, rst = 1'b1, gnt = 1'b0;
  logic [3:0] req = '0, wen = '0;
  logic [3:0][AW-1:0] add = '0;
  logic [3:0][DW-1:0] data = '0;
  logic [1:0] vld = '0;
  logic [DW-1:0] rdata = '0;
  logic [3:0] gnt4, vo4;
  logic [2:0] gnt3, vo3;
  logic [AW-1:0] ao4, ao3;
  logic [DW-1:0] do4, do3, rd4, rd3;
  logic ro4, ro3, wo4, wo3, st4, st3, er4, er3;
  st_t m [2];
  ent_t q [$];
  ent_t x;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  tcdm_master_arb u4 (.clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt4), .add_i(add), .wen_i(wen),
    .data_i(data), .rdata_o(rd4), .vld_o(vo4), .req_o(ro4), .gnt_i(gnt), .add_o(ao4), .wen_o(wo4),
    .data_o(do4), .rdata_i(rdata), .vld_i(vld[0]), .stall_o(st4), .err_o(er4));
  tcdm_master_arb #(.NumReq(3), .WriteRespOn(1'b0)) u3 (.clk_i(clk), .rst_i(rst), .req_i(req[2:0]),
    .gnt_o(gnt3), .add_i(add[2:0]), .wen_i(wen[2:0]), .data_i(data[2:0]), .rdata_o(rd3), .vld_o(vo3),
    .req_o(ro3), .gnt_i(gnt), .add_o(ao3), .wen_o(wo3), .data_o(do3), .rdata_i(rdata), .vld_i(vld[1]),
    .stall_o(st3), .err_o(er3));
  // reference model: returns this cycle's outputs, then advances to the post-edge state
  function automatic exp_t step(input int k);
    exp_t e;
    int n, w;
    bit hs;
    n = k == 0 ? 4 : 3;
    w = -1;
    e = '{default: '0};
    if (rst) begin
      m[k] = '{default: 0};
      return e;
    end
    if (m[k].lock && req[m[k].lid]) w = m[k].lid;
    else for (int i = 0; i < n; i++) if (w < 0 && req[(m[k].ptr + i) % n]) w = (m[k].ptr + i) % n;
    e.req = w >= 0;
    e.stall = m[k].cnt == THR;
    e.err = m[k].err;
    if (m[k].pend && vld[k]) e.vld[m[k].pid] = 1'b1;
    if (w >= 0) begin
      e.add = add[w];
      e.wen = wen[w];
      e.data = data[w];
      e.gnt[w] = gnt;
    end
    hs = w >= 0 && gnt;
    if (vld[k] != m[k].pend) m[k].err = 1'b1;
    m[k].pend = hs && (!e.wen || k == 0);
    if (hs) begin
      m[k].pid = w;
      m[k].ptr = (w + 1) % n;
    end
    m[k].lock = w >= 0 && !gnt;
    if (m[k].lock) m[k].lid = w;
    m[k].cnt = m[k].lock ? (m[k].cnt < THR ? m[k].cnt + 1 : THR) : 0;
    return e;
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, a, e);
  endtask
  // drive one cycle of stimulus and queue the model's expectation for it
  task automatic cyc(input logic [3:0] r, input bit g, input bit inj, input bit rs);
    ent_t t;
    @(posedge clk);
    #1;
    rst = rs;
    req = r;
    gnt = g;
    wen = 4'($urandom);
    rdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      add[i] = AW'($urandom);
      data[i] = $urandom;
    end
    for (int k = 0; k < 2; k++) vld[k] = m[k].pend ^ inj;
    t.e0 = step(0);
    t.e1 = step(1);
    t.rd = rdata;
    q.push_back(t);
  endtask
  // monitor: pop the expectation for whatever the DUTs present this cycle
  always @(negedge clk) if (q.size() > 0) begin
    x = q.pop_front();
    chk("req_o4", 64'(ro4), 64'(x.e0.req));
    chk("gnt_o4", 64'(gnt4), 64'(x.e0.gnt));
    chk("add_o4", 64'(ao4), 64'(x.e0.add));
    chk("wen_o4", 64'(wo4), 64'(x.e0.wen));
    chk("data_o4", 64'(do4), 64'(x.e0.data));
    chk("vld_o4", 64'(vo4), 64'(x.e0.vld));
    chk("stall_o4", 64'(st4), 64'(x.e0.stall));
    chk("err_o4", 64'(er4), 64'(x.e0.err));
    chk("rdata_o4", 64'(rd4), 64'(x.rd));
    chk("req_o3", 64'(ro3), 64'(x.e1.req));
    chk("gnt_o3", 64'(gnt3), 64'(x.e1.gnt[2:0]));
    chk("add_o3", 64'(ao3), 64'(x.e1.add));
    chk("wen_o3", 64'(wo3), 64'(x.e1.wen));
    chk("data_o3", 64'(do3), 64'(x.e1.data));
    chk("vld_o3", 64'(vo3), 64'(x.e1.vld[2:0]));
    chk("stall_o3", 64'(st3), 64'(x.e1.stall));
    chk("err_o3", 64'(er3), 64'(x.e1.err));
    chk("rdata_o3", 64'(rd3), 64'(x.rd));
  end
  initial begin
    repeat (2) cyc(4'($urandom), 1'b1, 1'b0, 1'b1);
    repeat (6) cyc(4'b0101, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(4'b0010, 1'b0, 1'b0, 1'b0);
    repeat (17) cyc(4'b0011, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(4'b0011, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(4'b1010, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(4'b1000, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (400) cyc(4'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(4'b1111, 1'b1, 1'b0, 1'b1);
    cyc(4'b0110, 1'b1, 1'b1, 1'b0);
    repeat (30) cyc(4'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    cyc(4'($urandom), 1'b1, 1'b0, 1'b1);
    repeat (30) cyc(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'b0);
    cyc(4'($urandom), 1'b1, 1'b0, 1'b1);
    repeat (50) cyc(4'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
